// File: rtl/instruction_fetch.sv
// Instruction fetch front end: drives the PC into a 1-cycle synchronous ROM and
// buffers returned words in a 2-entry FIFO presented to decode via valid/ready.
module instruction_fetch #(
    parameter int                     MEMORY_BITS = 8,
    parameter logic [MEMORY_BITS-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [MEMORY_BITS-1:0] imem_pc,
    input  logic [MEMORY_BITS-1:0] imem_instruction,
    output logic [MEMORY_BITS-1:0] instruction,
    output logic [MEMORY_BITS-1:0] instruction_pc,
    output logic                   instruction_valid,
    input  logic                   instruction_ready,
    input  logic                   redirect_valid,
    input  logic [MEMORY_BITS-1:0] redirect_pc,
    input  logic                   halt
);

    logic [MEMORY_BITS-1:0] fetch_pc;
    logic [MEMORY_BITS-1:0] pending_pc;
    logic                   pending;
    logic [MEMORY_BITS-1:0] fifo_word [2];
    logic [MEMORY_BITS-1:0] fifo_pc   [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occupancy;

    assign pop       = instruction_valid && instruction_ready;
    // Words already owed to the buffer after this cycle's pop; issuing only
    // when at most one is owed keeps the in-flight word from overflowing.
    assign occupancy = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    assign issue     = !halt && !redirect_valid && (occupancy <= 3'd1);
    assign push      = pending && !redirect_valid;

    assign imem_pc           = fetch_pc;
    assign instruction_valid = (count != 2'd0);
    assign instruction       = fifo_word[rd_ptr];
    assign instruction_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_word[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // Flush buffered and in-flight words; a same-cycle pop is simply absorbed.
            fetch_pc <= redirect_pc;
            pending  <= 1'b0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                fetch_pc   <= fetch_pc + MEMORY_BITS'(1);
                pending_pc <= fetch_pc;
            end
            if (push) begin
                fifo_word[wr_ptr] <= imem_instruction;
                fifo_pc[wr_ptr]   <= pending_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] imem_pc;
    logic [7:0] imem_instruction = 8'h00;
    logic [7:0] instruction;
    logic [7:0] instruction_pc;
    logic       instruction_valid;
    logic       instruction_ready = 1'b1;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halt = 1'b0;

    logic [7:0] irom [256];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_instruction <= irom[imem_pc];

    instruction_fetch #(.MEMORY_BITS(8), .RESET_PC(8'h00)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_pc           (imem_pc),
        .imem_instruction  (imem_instruction),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .halt              (halt)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: fetch address, words issued last cycle, buffered pcs.
    int m_fetch = 0;
    int q_inflight[$];
    int q_buf[$];

    always @(negedge clk) begin
        int  nb;
        bit  m_pop;
        bit  m_issue;
        if (rst) begin
            m_fetch = 0;
            q_inflight.delete();
            q_buf.delete();
            chk("rst_valid", 32'(instruction_valid), 32'd0);
            chk("rst_imem_pc", 32'(imem_pc), 32'd0);
        end else begin
            chk("m_imem_pc", 32'(imem_pc), 32'(m_fetch));
            chk("m_valid", 32'(instruction_valid), 32'(q_buf.size() != 0));
            if (q_buf.size() != 0) begin
                chk("m_instr", 32'(instruction), 32'(irom[q_buf[0]]));
                chk("m_instr_pc", 32'(instruction_pc), 32'(q_buf[0]));
            end
            chk("no_overflow", 32'(dut.count <= 2'd2), 32'd1);
            m_pop = (q_buf.size() != 0) && instruction_ready;
            if (redirect_valid) begin
                q_buf.delete();
                q_inflight.delete();
                m_fetch = int'(redirect_pc);
            end else begin
                nb      = q_buf.size() + q_inflight.size() - int'(m_pop);
                m_issue = !halt && (nb <= 1);
                if (m_pop) void'(q_buf.pop_front());
                if (q_inflight.size() != 0) q_buf.push_back(q_inflight.pop_front());
                if (m_issue) begin
                    q_inflight.push_back(m_fetch);
                    m_fetch = (m_fetch + 1) % 256;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) irom[k] = 8'(k + 16);
        #1;
        chk("reset_valid", 32'(instruction_valid), 32'd0);
        chk("reset_imem_pc", 32'(imem_pc), 32'd0);
        chk("reset_instr", 32'(instruction), 32'd0);
        chk("reset_instr_pc", 32'(instruction_pc), 32'd0);
        step(); step();
        rst = 1'b0;                                   // cycle C0
        chk("c0_imem_pc", 32'(imem_pc), 32'h00);
        chk("c0_valid", 32'(instruction_valid), 32'd0);
        step();
        chk("c1_imem_pc", 32'(imem_pc), 32'h01);
        chk("c1_valid", 32'(instruction_valid), 32'd0);
        step();                                       // C2: first valid
        chk("c2_valid", 32'(instruction_valid), 32'd1);
        chk("c2_instr", 32'(instruction), 32'h10);
        chk("c2_instr_pc", 32'(instruction_pc), 32'h00);
        chk("c2_imem_pc", 32'(imem_pc), 32'h02);
        instruction_ready = 1'b0;                     // backpressure C2..C6
        repeat (4) step();
        chk("bp_imem_frozen", 32'(imem_pc), 32'h02);
        chk("bp_hold", 32'(instruction), 32'h10);
        chk("bp_count_full", 32'(dut.count), 32'd2);
        step();
        instruction_ready = 1'b1;                     // C7
        chk("bp_resume_head", 32'(instruction), 32'h10);
        step();
        chk("bp_next1", 32'(instruction), 32'h11);
        chk("bp_next1_pc", 32'(instruction_pc), 32'h01);
        step();
        chk("bp_next2", 32'(instruction), 32'h12);
        chk("bp_next2_pc", 32'(instruction_pc), 32'h02);

        // fill buffer, then redirect while full (head popped in redirect cycle)
        step();
        instruction_ready = 1'b0;
        step();
        instruction_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect_valid = 1'b0;
        chk("rd_r1_valid", 32'(instruction_valid), 32'd0);
        chk("rd_r1_imem_pc", 32'(imem_pc), 32'h40);
        step();
        chk("rd_r2_valid", 32'(instruction_valid), 32'd0);
        chk("rd_r2_imem_pc", 32'(imem_pc), 32'h41);
        step();
        chk("rd_r3_instr", 32'(instruction), 32'h50);
        chk("rd_r3_instr_pc", 32'(instruction_pc), 32'h40);
        step();

        // redirect with a word in flight, target wraps past 0xFF
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect_valid = 1'b0;
        step(); step();
        chk("wrap_pc0", 32'(instruction_pc), 32'hFE);
        chk("wrap_w0", 32'(instruction), 32'h0E);
        step();
        chk("wrap_pc1", 32'(instruction_pc), 32'hFF);
        chk("wrap_w1", 32'(instruction), 32'h0F);
        step();
        chk("wrap_pc2", 32'(instruction_pc), 32'h00);
        chk("wrap_w2", 32'(instruction), 32'h10);
        step();
        chk("wrap_pc3", 32'(instruction_pc), 32'h01);

        // back-to-back redirects: last one wins
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        step();
        redirect_pc = 8'h20;
        step();
        redirect_valid = 1'b0;
        chk("b2b_imem_pc", 32'(imem_pc), 32'h20);
        chk("b2b_a2_valid", 32'(instruction_valid), 32'd0);
        step();
        chk("b2b_a3_valid", 32'(instruction_valid), 32'd0);
        step();
        chk("b2b_pc", 32'(instruction_pc), 32'h20);
        chk("b2b_word", 32'(instruction), 32'h30);

        // halt for 4 cycles while streaming
        halt = 1'b1;
        chk("halt_h0_imem_pc", 32'(imem_pc), 32'h22);
        step();
        chk("halt_h1_pc", 32'(instruction_pc), 32'h21);
        step();
        chk("halt_h2_valid", 32'(instruction_valid), 32'd0);
        step();
        chk("halt_h3_valid", 32'(instruction_valid), 32'd0);
        chk("halt_h3_imem_pc", 32'(imem_pc), 32'h22);
        step();
        halt = 1'b0;
        chk("halt_h4_imem_pc", 32'(imem_pc), 32'h22);
        step();
        chk("halt_h5_imem_pc", 32'(imem_pc), 32'h23);
        step();
        chk("halt_h6_pc", 32'(instruction_pc), 32'h22);
        chk("halt_h6_word", 32'(instruction), 32'h32);

        // redirect while halted: pc moves, nothing issues until halt drops
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h60;
        step();
        redirect_valid = 1'b0;
        chk("rdh_imem_pc", 32'(imem_pc), 32'h60);
        chk("rdh_valid", 32'(instruction_valid), 32'd0);
        step(); step();
        chk("rdh_hold_imem_pc", 32'(imem_pc), 32'h60);
        chk("rdh_hold_valid", 32'(instruction_valid), 32'd0);
        halt = 1'b0;
        step(); step();
        chk("rdh_pc", 32'(instruction_pc), 32'h60);
        chk("rdh_word", 32'(instruction), 32'h70);

        // asynchronous reset pulsed between edges
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk("areset_valid", 32'(instruction_valid), 32'd0);
        chk("areset_imem_pc", 32'(imem_pc), 32'h00);
        step();
        rst = 1'b0;
        chk("ar_c0_imem_pc", 32'(imem_pc), 32'h00);
        step(); step();
        chk("ar_c2_pc", 32'(instruction_pc), 32'h00);
        chk("ar_c2_word", 32'(instruction), 32'h10);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
